prio_encode_q: RTL

PRIO_ENCODE_Q -- requirements
Module: prio_encode_q

---
 rtl/prio_enc_pkg.sv | 13 +
 rtl/prio_encode_q_pick.sv | 32 +++
 rtl/prio_encode_q.sv | 79 +++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared helpers for the priority encoder: encoded-index width and the
// reset / fixed-mode value of the search start pointer.
package prio_enc_pkg;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/prio_encode_q_pick.sv
// Combinational picker: first set bit of i_vec searching downward from
// i_start, wrapping from 0 to N-1.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  // Walk offsets from farthest to nearest so the bit closest to i_start
  // (highest priority) is the last to write o_index.
  always_comb begin
    int p;
    p       = 0;
    o_found = 1'b0;
    o_index = '0;
    for (int j = N - 1; j >= 0; j--) begin
      p = int'(i_start) - j;
      if (p < 0) p = p + N;
      if (i_vec[p[W-1:0]]) begin
        o_found = 1'b1;
        o_index = p[W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_encode_q.sv
// Sticky-request priority encoder with a registered ready/valid output.
// Define PRIO_ENCODE_RR_EN for round-robin priority; default is fixed (MSB wins).
module prio_encode_q
  import prio_enc_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending
);

  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_code;

  logic [W-1:0] w_start;
  logic         w_found;
  logic [W-1:0] w_idx;
  logic         w_load;
  logic [N-1:0] w_clr;

`ifdef PRIO_ENCODE_RR_EN
  logic [W-1:0] r_ptr;

  assign w_start = r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ptr <= W'(ptr_rst(N));
    else if (w_load) r_ptr <= (w_idx == '0) ? W'(ptr_rst(N)) : w_idx - W'(1);
  end
`else
  assign w_start = W'(ptr_rst(N));
`endif

  prio_pick #(.N(N)) u_pick (
    .i_vec   (r_pending),
    .i_start (w_start),
    .o_found (w_found),
    .o_index (w_idx)
  );

  assign w_load = en && w_found && (!r_valid || out_ready);

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++)
      w_clr[i] = w_load && (int'(w_idx) == i);
  end

  // Clear of the granted bit is applied before OR-ing req_in, so a
  // same-cycle re-assert keeps the bit pending as a fresh event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
    end else begin
      if (en) r_pending <= (r_pending & ~w_clr) | req_in;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_idx;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign pending   = r_pending;

endmodule
